// File: rtl/ahblite_iq_fetch_ctrl_if.sv
// rtl/ahblite_iq_fetch_ctrl_if.sv - AHB-lite subordinate bus and fetch-engine port bundle
// slave: the fetch controller; master: the bus matrix / fetch engine side.
interface ahblite_iq_fetch_ctrl_if #(
  parameter int LEN_W = 16
);
  logic             HSEL;
  logic [31:0]      HADDR;
  logic [1:0]       HTRANS;
  logic [2:0]       HSIZE;
  logic [3:0]       HPROT;
  logic             HWRITE;
  logic [31:0]      HWDATA;
  logic             HREADY;
  logic             HREADYOUT;
  logic [31:0]      HRDATA;
  logic             HRESP;

  logic             fe_req;
  logic [2:0]       fe_ch;
  logic [31:0]      fe_addr;
  logic [LEN_W-1:0] fe_len;
  logic             fe_ack;
  logic             fe_done;
  logic [2:0]       fe_done_ch;

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP,
    output fe_req, fe_ch, fe_addr, fe_len,
    input  fe_ack, fe_done, fe_done_ch
  );

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP,
    input  fe_req, fe_ch, fe_addr, fe_len,
    output fe_ack, fe_done, fe_done_ch
  );
endinterface

// File: rtl/ahblite_iq_fetch_ctrl.sv
// rtl/ahblite_iq_fetch_ctrl.sv - multi-channel AHB-lite IQ fetch descriptor controller
// Define IQF_IRQ_EN to add per-channel IE bits and the registered irq output.
module ahblite_iq_fetch_ctrl #(
  parameter int NUM_CH = 4,
  parameter int LEN_W  = 16
) (
  input  logic HCLK,
  input  logic HRESETn,
`ifdef IQF_IRQ_EN
  output logic irq,
`endif
  ahblite_iq_fetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_ISSUED = 2'd2,
    ST_ACTIVE = 2'd3
  } ch_state_t;

  localparam logic [1:0] R_CTRL = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_LEN  = 2'd2;
  localparam logic [1:0] R_STAT = 2'd3;

  logic             dp_valid;
  logic             dp_write;
  logic             dp_word;
  logic [2:0]       dp_ch;
  logic [1:0]       dp_reg;

  ch_state_t        ch_state     [NUM_CH];
  ch_state_t        ch_state_nxt [NUM_CH];
  logic [31:0]      ch_addr      [NUM_CH];
  logic [31:0]      ch_addr_nxt  [NUM_CH];
  logic [LEN_W-1:0] ch_len       [NUM_CH];
  logic [LEN_W-1:0] ch_len_nxt   [NUM_CH];
  logic [NUM_CH-1:0] ch_done, ch_done_nxt;
  logic [NUM_CH-1:0] ch_err, ch_err_nxt;
`ifdef IQF_IRQ_EN
  logic [NUM_CH-1:0] ch_ie, ch_ie_nxt;
`endif

  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] done_hit;
  logic              wr_en;
  logic              ack_hit;

  logic              arb_busy;
  logic              grant_valid;
  logic [2:0]        grant_ch;
  logic [31:0]       grant_addr;
  logic [LEN_W-1:0]  grant_len;
  logic [2:0]        rr_ptr, rr_ptr_nxt;

  logic              fe_req_q;
  logic [2:0]        fe_ch_q;
  logic [31:0]       fe_addr_q;
  logic [LEN_W-1:0]  fe_len_q;
  logic [31:0]       rd_data;

  wire unused_bus_bits = &{1'b0, bus.HPROT, bus.HADDR[31:7], bus.HADDR[1:0], bus.HTRANS[0]};

  // Address phase capture; the write data arrives on HWDATA one cycle later.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_word  <= 1'b0;
      dp_ch    <= 3'd0;
      dp_reg   <= 2'd0;
    end else if (bus.HREADY) begin
      dp_valid <= bus.HSEL & bus.HTRANS[1];
      dp_write <= bus.HWRITE;
      dp_word  <= (bus.HSIZE == 3'b010);
      dp_ch    <= bus.HADDR[6:4];
      dp_reg   <= bus.HADDR[3:2];
    end
  end

  assign wr_en   = dp_valid & dp_write & dp_word;
  assign ack_hit = bus.fe_ack & fe_req_q;

  always_comb begin
    wr_hit   = '0;
    done_hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_hit[c]   = wr_en && (dp_ch == 3'(c));
      done_hit[c] = bus.fe_done && (bus.fe_done_ch == 3'(c)) && (ch_state[c] == ST_ACTIVE);
    end
  end

  // Round-robin search from rr_ptr, suppressed while a descriptor is in flight.
  always_comb begin
    arb_busy    = 1'b0;
    grant_valid = 1'b0;
    grant_ch    = 3'd0;
    grant_addr  = '0;
    grant_len   = '0;
    rr_ptr_nxt  = rr_ptr;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_state[c] == ST_ISSUED || ch_state[c] == ST_ACTIVE) arb_busy = 1'b1;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!grant_valid && !arb_busy && (c == (int'(rr_ptr) + i) % NUM_CH) &&
            ch_state[c] == ST_PEND) begin
          grant_valid = 1'b1;
          grant_ch    = 3'(c);
          grant_addr  = ch_addr[c];
          grant_len   = ch_len[c];
          rr_ptr_nxt  = 3'((c + 1) % NUM_CH);
        end
      end
    end
  end

  always_comb begin
    ch_done_nxt = ch_done;
    ch_err_nxt  = ch_err;
`ifdef IQF_IRQ_EN
    ch_ie_nxt   = ch_ie;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      ch_state_nxt[c] = ch_state[c];
      ch_addr_nxt[c]  = ch_addr[c];
      ch_len_nxt[c]   = ch_len[c];

      // W1C is applied first so that any set below on the same edge wins.
      if (wr_hit[c] && dp_reg == R_STAT) begin
        if (bus.HWDATA[2]) ch_done_nxt[c] = 1'b0;
        if (bus.HWDATA[3]) ch_err_nxt[c]  = 1'b0;
      end

      if (wr_hit[c] && dp_reg == R_CTRL) begin
`ifdef IQF_IRQ_EN
        ch_ie_nxt[c] = bus.HWDATA[1];
`endif
        if (bus.HWDATA[0]) begin
          if (ch_state[c] != ST_IDLE) begin
            ch_err_nxt[c] = 1'b1;
          end else if (ch_len[c] == '0) begin
            ch_done_nxt[c] = 1'b1;
          end else begin
            ch_state_nxt[c] = ST_PEND;
            ch_done_nxt[c]  = 1'b0;
          end
        end
      end

      if (wr_hit[c] && (dp_reg == R_ADDR || dp_reg == R_LEN)) begin
        if (ch_state[c] != ST_IDLE) begin
          ch_err_nxt[c] = 1'b1;
        end else if (dp_reg == R_ADDR) begin
          ch_addr_nxt[c] = {bus.HWDATA[31:2], 2'b00};
        end else begin
          ch_len_nxt[c] = bus.HWDATA[LEN_W-1:0];
        end
      end

      case (ch_state[c])
        ST_PEND:   if (grant_valid && grant_ch == 3'(c)) ch_state_nxt[c] = ST_ISSUED;
        ST_ISSUED: if (ack_hit) ch_state_nxt[c] = ST_ACTIVE;
        ST_ACTIVE: begin
          if (done_hit[c]) begin
            ch_state_nxt[c] = ST_IDLE;
            ch_done_nxt[c]  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ch_state[c] <= ST_IDLE;
        ch_addr[c]  <= '0;
        ch_len[c]   <= '0;
      end
      ch_done <= '0;
      ch_err  <= '0;
`ifdef IQF_IRQ_EN
      ch_ie   <= '0;
`endif
      rr_ptr  <= 3'd0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        ch_state[c] <= ch_state_nxt[c];
        ch_addr[c]  <= ch_addr_nxt[c];
        ch_len[c]   <= ch_len_nxt[c];
      end
      ch_done <= ch_done_nxt;
      ch_err  <= ch_err_nxt;
`ifdef IQF_IRQ_EN
      ch_ie   <= ch_ie_nxt;
`endif
      rr_ptr  <= rr_ptr_nxt;
    end
  end

  // Descriptor fields are loaded only on grant, so they hold while fe_req is up.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fe_req_q  <= 1'b0;
      fe_ch_q   <= 3'd0;
      fe_addr_q <= '0;
      fe_len_q  <= '0;
    end else if (grant_valid) begin
      fe_req_q  <= 1'b1;
      fe_ch_q   <= grant_ch;
      fe_addr_q <= grant_addr;
      fe_len_q  <= grant_len;
    end else if (ack_hit) begin
      fe_req_q  <= 1'b0;
    end
  end

`ifdef IQF_IRQ_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) irq <= 1'b0;
    else          irq <= |(ch_done & ch_ie);
  end
`endif

  always_comb begin
    rd_data = '0;
    if (dp_valid && !dp_write) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (dp_ch == 3'(c)) begin
          case (dp_reg)
            R_CTRL: begin
`ifdef IQF_IRQ_EN
              rd_data[1] = ch_ie[c];
`endif
            end
            R_ADDR:  rd_data = ch_addr[c];
            R_LEN:   rd_data[LEN_W-1:0] = ch_len[c];
            default: rd_data[3:0] = {ch_err[c], ch_done[c], ch_state[c]};
          endcase
        end
      end
    end
  end

  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;
  assign bus.HRDATA    = rd_data;
  assign bus.fe_req    = fe_req_q;
  assign bus.fe_ch     = fe_ch_q;
  assign bus.fe_addr   = fe_addr_q;
  assign bus.fe_len    = fe_len_q;

endmodule

// File: tb/tb_ahblite_iq_fetch_ctrl.sv
// tb/tb_ahblite_iq_fetch_ctrl.sv - scoreboard bench for ahblite_iq_fetch_ctrl
// Grants are predicted at START time and checked in order as the engine model accepts them.
module tb_ahblite_iq_fetch_ctrl;
  localparam int NUM_CH = 4;
  localparam int LEN_W  = 16;

  typedef struct packed {
    logic [2:0]       ch;
    logic [31:0]      addr;
    logic [LEN_W-1:0] len;
  } grant_t;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahblite_iq_fetch_ctrl_if #(.LEN_W(LEN_W)) bus ();
`ifdef IQF_IRQ_EN
  logic irq;
`endif

  ahblite_iq_fetch_ctrl #(.NUM_CH(NUM_CH), .LEN_W(LEN_W)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
`ifdef IQF_IRQ_EN
    .irq     (irq),
`endif
    .bus     (bus)
  );

  grant_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rd;
  logic        seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz = 3'b010);
    @(posedge HCLK); #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = a; bus.HSIZE = sz;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = d;
  endtask

  task automatic write_with_done(input logic [31:0] a, input logic [31:0] d, input logic [2:0] ch);
    bus_write(a, d);
    bus.fe_done = 1'b1; bus.fe_done_ch = ch;
    @(posedge HCLK); #1;
    bus.fe_done = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(posedge HCLK); #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = a; bus.HSIZE = 3'b010;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    @(negedge HCLK);
    d = bus.HRDATA;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(a, v);
    check(tag, v, exp);
  endtask

  task automatic expect_grant(input logic [2:0] ch, input logic [31:0] a, input logic [LEN_W-1:0] l);
    exp_q.push_back('{ch: ch, addr: a, len: l});
  endtask

  task automatic done_pulse(input logic [2:0] ch);
    @(negedge HCLK);
    bus.fe_done = 1'b1; bus.fe_done_ch = ch;
    @(posedge HCLK); #1;
    bus.fe_done = 1'b0;
  endtask

  // Engine model: accept the presented descriptor 3 cycles after seeing it.
  task automatic serve(input bit with_done);
    grant_t e;
    int n = 0;
    while (bus.fe_req !== 1'b1 && n < 100) begin
      @(negedge HCLK);
      n++;
    end
    if (bus.fe_req !== 1'b1) begin
      check("grant_timeout", {31'd0, bus.fe_req}, 32'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check("grant_unexpected", exp_q.size(), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check("grant_ch", bus.fe_ch, e.ch);
    check("grant_addr", bus.fe_addr, e.addr);
    check("grant_len", bus.fe_len, e.len);
    repeat (2) @(negedge HCLK);
    check("grant_stable", {bus.fe_ch, bus.fe_addr[28:0]}, {e.ch, e.addr[28:0]});
    bus.fe_ack = 1'b1;
    @(posedge HCLK); #1;
    bus.fe_ack = 1'b0;
    @(negedge HCLK);
    check("fe_req_drop", {31'd0, bus.fe_req}, 32'd0);
    if (with_done) done_pulse(e.ch);
  endtask

  initial begin
    bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HSIZE = 3'b010; bus.HPROT = 4'h3;
    bus.HWRITE = 1'b0; bus.HWDATA = '0; bus.HREADY = 1'b1;
    bus.fe_ack = 1'b0; bus.fe_done = 1'b0; bus.fe_done_ch = 3'd0;

    repeat (2) @(negedge HCLK);
    check("rst_fe_req", {31'd0, bus.fe_req}, 32'd0);
    check("rst_fe_addr", bus.fe_addr, 32'd0);
    check("rst_hrdata", bus.HRDATA, 32'd0);
    check("rst_hready_resp", {30'd0, bus.HREADYOUT, bus.HRESP}, 32'd2);
    HRESETn = 1'b1;

    // single descriptor on ch1 with first-grant latency
    bus_write(32'h14, 32'h2000_0040);
    bus_write(32'h18, 32'd8);
    expect_grant(3'd1, 32'h2000_0040, 16'd8);
    bus_write(32'h10, 32'h3);
    @(negedge HCLK); check("req_at_d", {31'd0, bus.fe_req}, 32'd0);
    @(negedge HCLK); check("req_at_d1", {31'd0, bus.fe_req}, 32'd0);
    @(negedge HCLK); check("req_at_d2", {31'd0, bus.fe_req}, 32'd1);
    serve(1'b0);
    read_check("ch1_active", 32'h1C, 32'h3);
    done_pulse(3'd1);
    read_check("ch1_done", 32'h1C, 32'h4);
`ifdef IQF_IRQ_EN
    check("irq_set", {31'd0, irq}, 32'd1);
    read_check("ch1_ctrl_ie", 32'h10, 32'h2);
`else
    read_check("ch1_ctrl", 32'h10, 32'h0);
`endif
    bus_write(32'h1C, 32'h4);
    read_check("ch1_w1c", 32'h1C, 32'h0);
`ifdef IQF_IRQ_EN
    check("irq_clr", {31'd0, irq}, 32'd0);
`endif

    // round robin 0,2,3
    bus_write(32'h04, 32'h1000_0000); bus_write(32'h08, 32'd4);
    bus_write(32'h24, 32'h1000_0200); bus_write(32'h28, 32'd5);
    bus_write(32'h34, 32'h1000_0300); bus_write(32'h38, 32'd6);
    expect_grant(3'd0, 32'h1000_0000, 16'd4);
    expect_grant(3'd2, 32'h1000_0200, 16'd5);
    expect_grant(3'd3, 32'h1000_0300, 16'd6);
    bus_write(32'h00, 32'h1);
    bus_write(32'h20, 32'h1);
    bus_write(32'h30, 32'h1);
    for (int i = 0; i < 3; i++) serve(1'b1);
    read_check("ch2_done_rr", 32'h2C, 32'h4);

    // ch2 in flight (pointer -> 3), then ch0 and ch3 queue behind it
    expect_grant(3'd2, 32'h1000_0200, 16'd5);
    bus_write(32'h20, 32'h1);
    serve(1'b0);
    bus_write(32'h20, 32'h1);
    bus_write(32'h00, 32'h1);
    bus_write(32'h30, 32'h1);
    expect_grant(3'd3, 32'h1000_0300, 16'd6);
    expect_grant(3'd0, 32'h1000_0000, 16'd4);
    bus_write(32'h08, 32'h77);
    check("no_req_while_active", {31'd0, bus.fe_req}, 32'd0);
    read_check("ch2_err_active", 32'h2C, 32'hB);
    read_check("ch0_len_kept", 32'h08, 32'd4);
    read_check("ch0_err_pend", 32'h0C, 32'h9);
    done_pulse(3'd2);
    serve(1'b1);
    serve(1'b1);
    check("sb_empty", exp_q.size(), 32'd0);
    read_check("ch0_after_wrap", 32'h0C, 32'hC);

    // stray done, then done coincident with W1C
    read_check("ch1_idle", 32'h1C, 32'h0);
    done_pulse(3'd1);
    read_check("ch1_stray_done", 32'h1C, 32'h0);
    expect_grant(3'd0, 32'h1000_0000, 16'd4);
    bus_write(32'h00, 32'h1);
    serve(1'b0);
    write_with_done(32'h0C, 32'h4, 3'd0);
    read_check("done_beats_w1c", 32'h0C, 32'hC);
    bus_write(32'h0C, 32'hC);
    read_check("ch0_cleared", 32'h0C, 32'h0);

    // LEN=0 start, sub-word write, address alignment, absent channel
    bus_write(32'h3C, 32'h4);
    bus_write(32'h38, 32'd0);
    bus_write(32'h30, 32'h1);
    seen = 1'b0;
    repeat (5) begin
      @(negedge HCLK);
      seen = seen | bus.fe_req;
    end
    check("len0_no_req", {31'd0, seen}, 32'd0);
    read_check("len0_done", 32'h3C, 32'h4);
    bus_write(32'h34, 32'hFFFF_FFFF, 3'b000);
    read_check("byte_write_ignored", 32'h34, 32'h1000_0300);
    bus_write(32'h04, 32'h1234_5677);
    read_check("addr_aligned", 32'h04, 32'h1234_5674);
    bus_write(32'h18, 32'hFFFF_1234);
    read_check("len_width", 32'h18, 32'h0000_1234);
    bus_write(32'h74, 32'hDEAD_BEEF);
    read_check("ch7_addr", 32'h74, 32'h0);
    read_check("ch7_status", 32'h7C, 32'h0);

    // asynchronous reset with a descriptor presented
    bus_write(32'h10, 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge HCLK);
      seen = bus.fe_req;
    end
    check("pre_rst_req", {31'd0, seen}, 32'd1);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = 32'h1C;
    #2 HRESETn = 1'b0;
    #1;
    check("rst_async_req", {31'd0, bus.fe_req}, 32'd0);
    check("rst_async_desc", {bus.fe_ch, bus.fe_addr[28:0]}, 32'd0);
    check("rst_async_len", {16'd0, bus.fe_len}, 32'd0);
`ifdef IQF_IRQ_EN
    check("rst_async_irq", {31'd0, irq}, 32'd0);
`endif
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    @(negedge HCLK);
    check("rst_async_hrdata", bus.HRDATA, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int c = 0; c < NUM_CH; c++) read_check("post_rst_status", 32'(c * 16 + 12), 32'h0);
    read_check("post_rst_addr", 32'h14, 32'h0);
    check("post_rst_req", {31'd0, bus.fe_req}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
